// File: rtl/multi_comparer_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_comparer_sync_if
// Brief    : Byte-stream and result bundle for multi_comparer_sync.
//            master = byte source / result consumer, slave = comparer.
// Revision : 1.0  initial release
// ============================================================================
interface multi_comparer_sync_if #(
    parameter int N = 2,
    parameter int L = 5,
    parameter int W = 8
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(L + 1);

    logic           flush;
    logic           load;
    logic [W-1:0]   data;
    logic           resolve;
    logic           reject;
    logic [IDW-1:0] match_id;
    logic [CW-1:0]  count;

    modport master (
        output flush, load, data,
        input  resolve, reject, match_id, count
    );

    modport slave (
        input  flush, load, data,
        output resolve, reject, match_id, count
    );
endinterface
`default_nettype wire

// File: rtl/multi_comparer_sync.sv
`default_nettype none
// ============================================================================
// Module   : multi_comparer_sync
// Brief    : Matches a byte stream against N fixed-length reference patterns
//            in parallel. Sticky resolve/reject, lowest-index winner, wildcard
//            reference bytes. Optional macro CASE_FOLD_EN enables ASCII
//            case-insensitive compare (reference wildcard test stays unfolded).
// Revision : 1.0  initial release
// ============================================================================
module multi_comparer_sync #(
    parameter int             N        = 2,
    parameter int             L        = 5,
    parameter int             W        = 8,
    parameter logic [N*L*W-1:0] REFS   = {"GPZDA", "GPRMC"},
    parameter logic [W-1:0]   WILDCARD = "?"
) (
    input  wire logic              clock,
    input  wire logic              restart,
    multi_comparer_sync_if.slave   bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(L + 1);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        DONE_OK   = 2'd1,
        DONE_FAIL = 2'd2
    } state_t;

    state_t          r_state,  w_state_nx;
    logic [N-1:0]    r_alive,  w_alive_nx;
    logic [CW-1:0]   r_count,  w_count_nx;
    logic [IDW-1:0]  r_id,     w_id_nx;

    logic [N-1:0]    w_eq;
    logic [N-1:0]    w_hit;
    logic [IDW-1:0]  w_low;
    logic [W-1:0]    w_ref;
    int              w_pos;

`ifdef CASE_FOLD_EN
    // Lower-case ASCII letters in the low byte map to upper case; any upper
    // bits of a wider byte pass through untouched.
    function automatic logic [W-1:0] fold(input logic [W-1:0] b);
        logic [W-1:0] f;
        f = b;
        if (b[7:0] >= 8'h61 && b[7:0] <= 8'h7A) begin
            f[7:0] = b[7:0] - 8'h20;
        end
        return f;
    endfunction
`endif

    // Per-pattern byte compare at the current position; count is clamped so
    // the select stays in range once the comparer has finished.
    always_comb begin
        w_eq  = '0;
        w_ref = '0;
        w_pos = (r_count < CW'(L)) ? int'(r_count) : 0;
        for (int i = 0; i < N; i++) begin
            w_ref = REFS[(N-i)*L*W-1-w_pos*W -: W];
`ifdef CASE_FOLD_EN
            w_eq[i] = (w_ref == WILDCARD) || (fold(w_ref) == fold(bus.data));
`else
            w_eq[i] = (w_ref == WILDCARD) || (w_ref == bus.data);
`endif
        end
    end

    // Lowest-index survivor wins when several patterns are still alive.
    always_comb begin
        w_hit = r_alive & w_eq;
        w_low = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_low = IDW'(i);
            end
        end
    end

    // Next-state: flush re-arms; a loaded byte in HUNT narrows the alive set
    // and may decide the outcome on the same edge.
    always_comb begin
        w_state_nx = r_state;
        w_alive_nx = r_alive;
        w_count_nx = r_count;
        w_id_nx    = r_id;
        if (bus.flush) begin
            w_state_nx = HUNT;
            w_alive_nx = '1;
            w_count_nx = '0;
            w_id_nx    = '0;
        end else if (r_state == HUNT && bus.load) begin
            w_alive_nx = w_hit;
            w_count_nx = r_count + CW'(1);
            if (w_hit == '0) begin
                w_state_nx = DONE_FAIL;
            end else if (r_count == CW'(L - 1)) begin
                w_state_nx = DONE_OK;
                w_id_nx    = w_low;
            end
        end
    end

    // State register with asynchronous re-arm.
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            r_state <= HUNT;
            r_alive <= '1;
            r_count <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_alive <= w_alive_nx;
            r_count <= w_count_nx;
            r_id    <= w_id_nx;
        end
    end

    assign bus.resolve  = (r_state == DONE_OK);
    assign bus.reject   = (r_state == DONE_FAIL);
    assign bus.match_id = r_id;
    assign bus.count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multi_comparer_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_comparer_sync
// Brief    : Scoreboard bench for multi_comparer_sync. Two instances share the
//            byte stream: default REFS and {"GP???","GPZDA"}. A prefix-match
//            reference model predicts every cycle's outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_comparer_sync;
    localparam logic [79:0] REF0 = {"GPZDA", "GPRMC"};
    localparam logic [79:0] REF1 = {"GP???", "GPZDA"};
    localparam logic [7:0]  WILD = "?";

    typedef struct packed {
        logic       res;
        logic       rej;
        logic       id;
        logic [2:0] cnt;
    } exp_t;

    logic clock;
    logic restart;

    multi_comparer_sync_if #(.N(2), .L(5), .W(8)) b0 ();
    multi_comparer_sync_if #(.N(2), .L(5), .W(8)) b1 ();

    multi_comparer_sync #(.N(2), .L(5), .W(8), .REFS(REF0), .WILDCARD("?")) dut0 (
        .clock   (clock),
        .restart (restart),
        .bus     (b0.slave)
    );

    multi_comparer_sync #(.N(2), .L(5), .W(8), .REFS(REF1), .WILDCARD("?")) dut1 (
        .clock   (clock),
        .restart (restart),
        .bus     (b1.slave)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    // ---------------- reference model ----------------
    int         m_n   [2];
    logic [7:0] m_hist[2][5];
    bit         m_res [2];
    bit         m_rej [2];
    int         m_win [2];

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef CASE_FOLD_EN
        if (b >= "a" && b <= "z") return b - 8'h20;
`endif
        return b;
    endfunction

    function automatic logic [7:0] ref_byte(input int d, input int i, input int k);
        logic [79:0] r;
        r = (d == 0) ? REF0 : REF1;
        return r[(2-i)*40-1-k*8 -: 8];
    endfunction

    // Pattern i agrees with every byte received so far.
    function automatic bit prefix_ok(input int d, input int i);
        logic [7:0] rb;
        for (int k = 0; k < m_n[d]; k++) begin
            rb = ref_byte(d, i, k);
            if (rb != WILD && fold(rb) != fold(m_hist[d][k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_res[d] = 0; m_rej[d] = 0; m_win[d] = 0;
        end
    endtask

    task automatic m_step(input int d, input logic [7:0] b);
        int win;
        if (m_res[d] || m_rej[d]) return;
        m_hist[d][m_n[d]] = b;
        m_n[d]++;
        win = -1;
        for (int i = 1; i >= 0; i--) if (prefix_ok(d, i)) win = i;
        if (win < 0) m_rej[d] = 1;
        else if (m_n[d] == 5) begin
            m_res[d] = 1;
            m_win[d] = win;
        end
    endtask

    function automatic exp_t m_exp(input int d);
        exp_t e;
        e.res = m_res[d];
        e.rej = m_rej[d];
        e.id  = m_res[d] ? m_win[d][0] : 1'b0;
        e.cnt = 3'(m_n[d]);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input bit rs, input bit fl, input bit ld, input logic [7:0] d);
        @(negedge clock);
        restart  = rs;
        b0.flush = fl; b0.load = ld; b0.data = d;
        b1.flush = fl; b1.load = ld; b1.data = d;
        if (rs || fl) m_reset();
        else if (ld) begin
            m_step(0, d);
            m_step(1, d);
        end
        q0.push_back(m_exp(0));
        q1.push_back(m_exp(1));
        @(posedge clock);
    endtask

    task automatic feed(input string s);
        for (int k = 0; k < s.len(); k++) cyc(0, 0, 1, s[k]);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("dut0.resolve",  int'(b0.resolve),  int'(e.res));
            chk("dut0.reject",   int'(b0.reject),   int'(e.rej));
            chk("dut0.match_id", int'(b0.match_id), int'(e.id));
            chk("dut0.count",    int'(b0.count),    int'(e.cnt));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("dut1.resolve",  int'(b1.resolve),  int'(e.res));
            chk("dut1.reject",   int'(b1.reject),   int'(e.rej));
            chk("dut1.match_id", int'(b1.match_id), int'(e.id));
            chk("dut1.count",    int'(b1.count),    int'(e.cnt));
        end
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        string pats[3];
        string s;
        logic [7:0] c;
        pats[0] = "GPZDA"; pats[1] = "GPRMC"; pats[2] = "GPXYZ";
        restart = 1'b1;
        b0.flush = 0; b0.load = 0; b0.data = 0;
        b1.flush = 0; b1.load = 0; b1.data = 0;
        m_reset();

        // reset held two cycles, then released
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // full match on pattern 0, then loads ignored
        feed("GPZDA");
        feed("XXX");

        // pattern 1 with gaps
        cyc(0, 1, 0, 0);
        s = "GPRMC";
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, s[k]);
            if (k < 4) cyc(0, 0, 0, "x");
        end

        // early reject, later bytes ignored
        cyc(0, 1, 0, 0);
        feed("GPX");
        feed("AB");

        // flush mid-pattern discards the simultaneous load
        cyc(0, 1, 0, 0);
        feed("GP");
        cyc(0, 1, 1, "Z");
        feed("GPZDA");

        // restart mid-pattern
        feed("GP");
        cyc(1, 0, 1, "R");
        cyc(0, 0, 0, 0);
        feed("GPRMC");

        // lower-case input
        cyc(0, 1, 0, 0);
        feed("gpzda");

        // randomized trials: near-miss patterns, gaps, case changes, re-arms
        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 3) == 0) cyc(1, 0, $urandom_range(0, 1), "G");
            else cyc(0, 1, $urandom_range(0, 1), "G");
            s = pats[$urandom_range(0, 2)];
            for (int k = 0; k < 7; k++) begin
                c = (k < 5) ? s[k] : "Q";
                if ($urandom_range(0, 9) == 0) c = 8'($urandom_range(65, 90));
                if ($urandom_range(0, 7) == 0 && c >= "A" && c <= "Z") c = c + 8'h20;
                if ($urandom_range(0, 4) == 0) cyc(0, 0, 0, 8'($urandom));
                if ($urandom_range(0, 29) == 0) cyc(0, 1, 1, c);
                else cyc(0, 0, 1, c);
            end
        end

        cyc(0, 0, 0, 0);
        @(posedge clock);
        #2;
        chk("queue0.drained", q0.size(), 0);
        chk("queue1.drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
